// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the integer ALU and its built-in self-test engine:
// ALU opcode encodings, the BIST polynomial used by both the operand LFSR
// and the response MISR, the operand whitening constant, the BIST state
// encoding and the MISR compaction step.
package alu_pkg;

    // ALU opcodes exercised by the self-test, in the order they are applied
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    // Feedback polynomial shared by the operand LFSR and the signature MISR
    localparam logic [31:0] BIST_POLY = 32'h80200003;

    // XOR mask applied to the swapped LFSR word so operand b is not a plain
    // rotation of operand a
    localparam logic [31:0] BIST_WHITEN = 32'h5A5A5A5A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } bist_state_t;

    // One MISR compaction step: shift left with polynomial feedback, then
    // fold in the ALU result and its zero flag (the flag lands on bit 0)
    function automatic logic [31:0] misr_next(
        input logic [31:0] sig,
        input logic [31:0] result,
        input logic        zero
    );
        logic [31:0] shifted;
        shifted = {sig[30:0], 1'b0} ^ (sig[31] ? BIST_POLY : 32'h0);
        return shifted ^ result ^ {31'b0, zero};
    endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// bist_lfsr32
// 32-bit Galois LFSR used as a pseudo-random pattern source for BIST
// engines. An all-zero seed would lock the register at zero, so any zero
// seed (reset or load) is replaced by 32'h00000001.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   rst     in   1   asynchronous active-high reset, loads RESET_SEED
//   load    in   1   load seed this cycle (has priority over enable)
//   seed    in   32  value loaded when load=1
//   enable  in   1   advance one step this cycle
//   state   out  32  current LFSR contents
module bist_lfsr32
    import alu_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = 32'h00000001,
    parameter logic [31:0] POLY       = BIST_POLY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        enable,
    output logic [31:0] state
);

    localparam logic [31:0] SAFE_RESET_SEED =
        (RESET_SEED == 32'h0) ? 32'h00000001 : RESET_SEED;

    logic [31:0] lfsr_q;
    logic [31:0] safe_seed;
    logic [31:0] lfsr_step;

    // Zero-seed substitution and the Galois shift: shift right and, when the
    // bit falling out is 1, XOR in the polynomial taps
    always_comb begin
        safe_seed = (seed == 32'h0) ? 32'h00000001 : seed;
        lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
    end

    // Seed load wins over stepping so a restart always begins from the seed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SAFE_RESET_SEED;
        end else if (load) begin
            lfsr_q <= safe_seed;
        end else if (enable) begin
            lfsr_q <= lfsr_step;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/alu_bist.sv
// alu_bist
// Built-in self-test engine for the integer ALU. On start it applies
// N_VECTORS pseudo-random operand pairs (ADD, SUB, AND, OR repeating),
// compacts every {result, zero} response into a 32-bit MISR and compares
// the final signature against GOLDEN_SIG.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   start        in   1   run request, honoured in IDLE or DONE only
//   busy         out  1   vectors are being applied
//   done         out  1   run complete, held until next start or reset
//   pass         out  1   done and signature matches GOLDEN_SIG
//   signature    out  32  current MISR value, frozen in DONE
//   alu_a        out  32  ALU operand a (0 outside a run)
//   alu_b        out  32  ALU operand b (0 outside a run)
//   alu_control  out  4   ALU opcode (0 outside a run)
//   alu_result   in   32  ALU result, combinational from the operands
//   alu_zero     in   1   ALU zero flag
module alu_bist
    import alu_pkg::*;
#(
    parameter int          N_VECTORS  = 256,
    parameter logic [31:0] LFSR_SEED  = 32'hACE12468,
    parameter logic [31:0] GOLDEN_SIG = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    localparam logic [15:0] LAST_CNT = 16'(N_VECTORS - 1);

    bist_state_t state_q;
    bist_state_t state_d;
    logic        lfsr_load;
    logic        lfsr_en;
    logic [31:0] lfsr;
    logic [31:0] sig_q;
    logic [15:0] cnt_q;

    bist_lfsr32 #(
        .RESET_SEED (LFSR_SEED),
        .POLY       (BIST_POLY)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .seed   (LFSR_SEED),
        .enable (lfsr_en),
        .state  (lfsr)
    );

    // Next-state logic. An accepted start reloads the LFSR and is also the
    // cue for the counter and MISR to clear; start during RUN is ignored.
    always_comb begin
        state_d   = state_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    lfsr_load = 1'b1;
                end
            end
            ST_RUN: begin
                lfsr_en = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Vector counter and signature. Each RUN edge absorbs the vector that
    // was on the ALU during the cycle just ending; outside RUN both hold,
    // which freezes the final signature in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'h0;
            sig_q <= 32'h0;
        end else if (lfsr_load) begin
            cnt_q <= 16'h0;
            sig_q <= 32'h0;
        end else if (state_q == ST_RUN) begin
            cnt_q <= cnt_q + 16'h1;
            sig_q <= misr_next(sig_q, alu_result, alu_zero);
        end
    end

    // Operand drive comes only from registers, so start has no
    // combinational path to the ALU. Outside RUN the ALU inputs are parked
    // at zero.
    always_comb begin
        busy        = (state_q == ST_RUN);
        done        = (state_q == ST_DONE);
        pass        = done && (sig_q == GOLDEN_SIG);
        signature   = sig_q;
        alu_a       = 32'h0;
        alu_b       = 32'h0;
        alu_control = 4'h0;
        if (state_q == ST_RUN) begin
            alu_a       = lfsr;
            alu_b       = {lfsr[15:0], lfsr[31:16]} ^ BIST_WHITEN;
            alu_control = {2'b00, cnt_q[1:0]};
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist
// Directed self-checking bench for alu_bist. Three instances share clock
// and reset:
//   dut_a  N_VECTORS=4,   seed 1            reset state, vector timing,
//                                           start while busy, restart
//   dut_b  N_VECTORS=256, default seed      golden run, fault, mid-run reset
//   dut_c  N_VECTORS=4,   seed 0            zero-seed substitution
// Each instance drives a behavioural ALU; dut_b's ALU can flip result[0]
// on vector 2 of a run.
module tb_alu_bist;
    import alu_pkg::*;

    // Behavioural reference for the whole run: operand generation, ALU and
    // MISR written out from the algorithm description
    function automatic logic [31:0] model_sig(input logic [31:0] seed, input int n);
        logic [31:0] l;
        logic [31:0] s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [1:0]  op;
        l = (seed == 32'h0) ? 32'h1 : seed;
        s = 32'h0;
        for (int k = 0; k < n; k++) begin
            a  = l;
            b  = {l[15:0], l[31:16]} ^ 32'h5A5A5A5A;
            op = k[1:0];
            case (op)
                2'd0:    r = a + b;
                2'd1:    r = a - b;
                2'd2:    r = a & b;
                default: r = a | b;
            endcase
            s = {s[30:0], 1'b0} ^ (s[31] ? 32'h80200003 : 32'h0) ^ r ^ {31'b0, (r == 32'h0)};
            l = {1'b0, l[31:1]} ^ (l[0] ? 32'h80200003 : 32'h0);
        end
        return s;
    endfunction

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] ctl);
        case (ctl)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            default: return 32'h0;
        endcase
    endfunction

    localparam logic [31:0] SEED_B   = 32'hACE12468;
    localparam logic [31:0] GOLDEN_A = model_sig(32'h00000001, 4);
    localparam logic [31:0] GOLDEN_B = model_sig(SEED_B, 256);

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start_a = 1'b0;
    logic        busy_a, done_a, pass_a, zero_a;
    logic [31:0] sig_a, a_a, b_a, res_a;
    logic [3:0]  ctl_a;

    logic        start_b = 1'b0;
    logic        busy_b, done_b, pass_b, zero_b;
    logic [31:0] sig_b, a_b, b_b, res_b, res_b_raw;
    logic [3:0]  ctl_b;
    logic        fault_en = 1'b0;
    int          vec_idx_b = 0;

    logic        start_c = 1'b0;
    logic        busy_c, done_c, pass_c, zero_c;
    logic [31:0] sig_c, a_c, b_c, res_c;
    logic [3:0]  ctl_c;

    int n_vectors = 0;
    int n_miss    = 0;

    always #5 clk = ~clk;

    // Behavioural ALUs; dut_b's zero flag is taken from the fault-free
    // result so only result[0] is disturbed
    always_comb begin
        res_a     = alu_fn(a_a, b_a, ctl_a);
        zero_a    = (res_a == 32'h0);
        res_b_raw = alu_fn(a_b, b_b, ctl_b);
        zero_b    = (res_b_raw == 32'h0);
        res_b     = res_b_raw ^ {31'b0, (fault_en && busy_b && vec_idx_b == 2)};
        res_c     = alu_fn(a_c, b_c, ctl_c);
        zero_c    = (res_c == 32'h0);
    end

    // Index of the vector currently presented by dut_b
    always @(posedge clk) begin
        if (busy_b) vec_idx_b <= vec_idx_b + 1;
        else        vec_idx_b <= 0;
    end

    alu_bist #(.N_VECTORS(4), .LFSR_SEED(32'h00000001), .GOLDEN_SIG(GOLDEN_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .signature(sig_a), .alu_a(a_a), .alu_b(b_a),
        .alu_control(ctl_a), .alu_result(res_a), .alu_zero(zero_a)
    );

    alu_bist #(.N_VECTORS(256), .LFSR_SEED(SEED_B), .GOLDEN_SIG(GOLDEN_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .signature(sig_b), .alu_a(a_b), .alu_b(b_b),
        .alu_control(ctl_b), .alu_result(res_b), .alu_zero(zero_b)
    );

    alu_bist #(.N_VECTORS(4), .LFSR_SEED(32'h00000000), .GOLDEN_SIG(32'h0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
        .pass(pass_c), .signature(sig_c), .alu_a(a_c), .alu_b(b_c),
        .alu_control(ctl_c), .alu_result(res_c), .alu_zero(zero_c)
    );

    // All outputs of dut_a read zero while reset is held
    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_vectors++;
        if ({busy_a, done_a, pass_a} !== 3'b000) begin
            n_miss++;
            $display("[TB] FAIL reset_flags busy/done/pass=%b expected 000", {busy_a, done_a, pass_a});
        end
        n_vectors++;
        if (sig_a !== 32'h0) begin
            n_miss++;
            $display("[TB] FAIL reset_sig got %h expected 00000000", sig_a);
        end
        n_vectors++;
        if ({a_a, b_a, ctl_a} !== 68'h0) begin
            n_miss++;
            $display("[TB] FAIL reset_operands a=%h b=%h ctl=%h expected 0", a_a, b_a, ctl_a);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // First two vectors of a seed-1 run checked by hand, then done timing
    task automatic test_first_vector();
        int cyc;
        start_a = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start_a = 1'b0;
        n_vectors++;
        if (busy_a !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL v0_busy got %b expected 1", busy_a);
        end
        n_vectors++;
        if ({a_a, b_a, ctl_a} !== {32'h00000001, 32'h5A5B5A5A, 4'b0000}) begin
            n_miss++;
            $display("[TB] FAIL v0_operands a=%h b=%h ctl=%h expected 00000001 5a5b5a5a 0", a_a, b_a, ctl_a);
        end
        n_vectors++;
        if (res_a !== 32'h5A5B5A5B) begin
            n_miss++;
            $display("[TB] FAIL v0_result got %h expected 5a5b5a5b", res_a);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        n_vectors++;
        if (sig_a !== 32'h5A5B5A5B) begin
            n_miss++;
            $display("[TB] FAIL v0_absorbed sig got %h expected 5a5b5a5b", sig_a);
        end
        n_vectors++;
        if ({a_a, ctl_a, res_a} !== {32'h80200003, 4'b0001, 32'h25C62589}) begin
            n_miss++;
            $display("[TB] FAIL v1 a=%h ctl=%h res=%h expected 80200003 1 25c62589", a_a, ctl_a, res_a);
        end
        while (!done_a && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        n_vectors++;
        if (cyc !== 5 || done_a !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL done_latency got %0d cycles (done=%b) expected 5", cyc, done_a);
        end
        n_vectors++;
        if ({busy_a, pass_a} !== 2'b01 || sig_a !== GOLDEN_A) begin
            n_miss++;
            $display("[TB] FAIL short_run busy=%b pass=%b sig=%h expected 0 1 %h", busy_a, pass_a, sig_a, GOLDEN_A);
        end
    endtask

    // Start in DONE clears done/pass on the same edge and reruns identically
    task automatic test_restart();
        int cyc;
        start_a = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start_a = 1'b0;
        n_vectors++;
        if ({busy_a, done_a, pass_a} !== 3'b100) begin
            n_miss++;
            $display("[TB] FAIL restart_flags busy/done/pass=%b expected 100", {busy_a, done_a, pass_a});
        end
        while (!done_a && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        n_vectors++;
        if (cyc !== 5 || sig_a !== GOLDEN_A || pass_a !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL restart_sig cyc=%0d sig=%h pass=%b expected 5 %h 1", cyc, sig_a, pass_a, GOLDEN_A);
        end
    endtask

    // A second start during RUN must not restart or delay the run
    task automatic test_back_to_back();
        int cyc;
        start_a = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start_a = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        start_a = 1'b0;
        n_vectors++;
        if (busy_a !== 1'b1 || ctl_a !== ALU_AND) begin
            n_miss++;
            $display("[TB] FAIL busy_start busy=%b ctl=%h expected 1 2", busy_a, ctl_a);
        end
        while (!done_a && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        n_vectors++;
        if (cyc !== 5 || sig_a !== GOLDEN_A) begin
            n_miss++;
            $display("[TB] FAIL busy_start_done cyc=%0d sig=%h expected 5 %h", cyc, sig_a, GOLDEN_A);
        end
    endtask

    // Full-length run on dut_b, with or without the injected ALU fault
    task automatic test_golden(input logic with_fault);
        int cyc;
        fault_en = with_fault;
        start_b  = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start_b = 1'b0;
        while (!done_b && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        if (!with_fault) begin
            n_vectors++;
            if (cyc !== 257 || pass_b !== 1'b1 || sig_b !== GOLDEN_B) begin
                n_miss++;
                $display("[TB] FAIL golden cyc=%0d pass=%b sig=%h expected 257 1 %h", cyc, pass_b, sig_b, GOLDEN_B);
            end
        end else begin
            n_vectors++;
            if (done_b !== 1'b1 || pass_b !== 1'b0 || sig_b === GOLDEN_B) begin
                n_miss++;
                $display("[TB] FAIL fault_detect done=%b pass=%b sig=%h expected 1 0 and sig != %h", done_b, pass_b, sig_b, GOLDEN_B);
            end
        end
        fault_en = 1'b0;
        @(negedge clk);
    endtask

    // Asynchronous reset during vector 2 discards the partial run at once
    task automatic test_midrun_reset();
        start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_vectors++;
        if ({busy_b, done_b, pass_b} !== 3'b000 || a_b !== 32'h0 || sig_b !== 32'h0) begin
            n_miss++;
            $display("[TB] FAIL midrun_reset busy/done/pass=%b a=%h sig=%h expected 000 0 0", {busy_b, done_b, pass_b}, a_b, sig_b);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_golden(1'b0);
    endtask

    // A zero seed is replaced by 1
    task automatic test_zero_seed();
        start_c = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_c = 1'b0;
        n_vectors++;
        if (a_c !== 32'h00000001 || b_c !== 32'h5A5B5A5A) begin
            n_miss++;
            $display("[TB] FAIL zero_seed a=%h b=%h expected 00000001 5a5b5a5a", a_c, b_c);
        end
        repeat (6) @(negedge clk);
        n_vectors++;
        if (done_c !== 1'b1 || sig_c !== GOLDEN_A) begin
            n_miss++;
            $display("[TB] FAIL zero_seed_sig done=%b sig=%h expected 1 %h", done_c, sig_c, GOLDEN_A);
        end
    endtask

    initial begin
        $display("[TB] alu_bist directed test, golden A=%h B=%h", GOLDEN_A, GOLDEN_B);
        test_reset();
        test_first_vector();
        test_restart();
        test_back_to_back();
        test_golden(1'b0);
        test_golden(1'b1);
        test_midrun_reset();
        test_zero_seed();
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miss);
        $finish;
    end

endmodule
